// File: rtl/t05_stage_sequencer.sv
// t05_stage_sequencer: walks one compression run through five pipeline
// stages (HIST, FLV, HTREE, CBS, TRANS), reporting completion, a sticky
// error and the run length in cycles.
// Optional per-stage watchdog compiled in with macro T05_STAGE_WDOG_EN.
module t05_stage_sequencer #(
  parameter logic [23:0] WDOG_CYCLES = 24'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  fin_state,
  output logic [3:0]  en_state,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [31:0] run_cycles
);

  // Stage states carry their own stage number so the expected completion
  // code is simply the current encoding plus one.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HIST  = 3'd1,
    S_FLV   = 3'd2,
    S_HTREE = 3'd3,
    S_CBS   = 3'd4,
    S_TRANS = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  en_state_q, en_state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [31:0] run_cycles_q, run_cycles_d;
  logic [2:0]  stage_num;
  logic [2:0]  next_code;

`ifdef T05_STAGE_WDOG_EN
  logic [23:0] wdog_q, wdog_d;
  logic        wdog_expired;
  assign wdog_expired = (wdog_q == WDOG_CYCLES - 24'd1);
`else
  logic unused_wdog_cycles;
  assign unused_wdog_cycles = ^WDOG_CYCLES;
`endif

  assign stage_num = state_q;
  assign next_code = stage_num + 3'd1;

  // Next-state, error capture and run-length counting.
  always_comb begin
    state_d      = state_q;
    err_code_d   = '0;
    run_cycles_d = run_cycles_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_HIST;
          run_cycles_d = '0;
        end
      end
      S_HIST, S_FLV, S_HTREE, S_CBS, S_TRANS: begin
        if (run_cycles_q != '1) run_cycles_d = run_cycles_q + 32'd1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (fin_state == next_code) begin
          // TRANS (5) + 1 lands on DONE (6), so all stages share this path.
          state_d = state_t'(next_code);
        end else if (fin_state != 3'd0) begin
          state_d    = S_ERR;
          err_code_d = stage_num;
`ifdef T05_STAGE_WDOG_EN
        end else if (wdog_expired) begin
          state_d    = S_ERR;
          err_code_d = stage_num;
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d      = S_HIST;
          run_cycles_d = '0;
        end else begin
          err_code_d = err_code_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered output values derived from the upcoming state.
  always_comb begin
    en_state_d = (state_d == S_ERR) ? 4'd0 : {1'b0, state_d};
    busy_d     = state_d inside {S_HIST, S_FLV, S_HTREE, S_CBS, S_TRANS};
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

`ifdef T05_STAGE_WDOG_EN
  // Watchdog restarts on each stage entry and counts while the stage holds.
  always_comb begin
    wdog_d = '0;
    if (busy_d && (state_d == state_q)) wdog_d = wdog_q + 24'd1;
  end
`endif

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      en_state_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
      run_cycles_q <= '0;
`ifdef T05_STAGE_WDOG_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      en_state_q   <= en_state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      run_cycles_q <= run_cycles_d;
`ifdef T05_STAGE_WDOG_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  assign en_state   = en_state_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_t05_stage_sequencer.sv
// Bench for t05_stage_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a model.
module tb_t05_stage_sequencer;

`ifdef T05_STAGE_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int WDOG = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  fin_state = 3'd0;
  logic [3:0]  en_state;
  logic        busy, done, err;
  logic [2:0]  err_code;
  logic [31:0] run_cycles;

  int n_chk = 0;
  int n_pass = 0;

  t05_stage_sequencer #(.WDOG_CYCLES(24'(WDOG))) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .fin_state(fin_state), .en_state(en_state), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model. m_st: 0 idle, 1..5 active stage, 6 done, 7 error.
  int          m_st = 0;
  int          m_nxt;
  int          m_wd = 0;
  logic [2:0]  m_code = 3'd0;
  logic [31:0] m_cyc = 32'd0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_st = 0; m_wd = 0; m_code = 3'd0; m_cyc = 32'd0;
    end else begin
      m_nxt = m_st;
      if (m_st >= 1 && m_st <= 5) begin
        if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
        if (abort) m_nxt = 0;
        else if (int'(fin_state) == m_st + 1) m_nxt = m_st + 1;
        else if (fin_state != 3'd0) begin m_nxt = 7; m_code = 3'(m_st); end
        else if (WD && m_wd == WDOG - 1) begin m_nxt = 7; m_code = 3'(m_st); end
        m_wd = (m_nxt == m_st) ? m_wd + 1 : 0;
      end else if (m_st == 6) begin
        m_nxt = 0;
      end else if (m_st == 7) begin
        if (abort) begin m_nxt = 0; m_code = 3'd0; end
        else if (start) begin m_nxt = 1; m_code = 3'd0; m_cyc = 32'd0; m_wd = 0; end
      end else if (start) begin
        m_nxt = 1; m_cyc = 32'd0; m_wd = 0;
      end
      if (m_nxt == 0) m_code = 3'd0;
      m_st = m_nxt;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  logic [41:0] act_v, exp_v;
  initial forever begin
    @(negedge clk);
    act_v = {en_state, busy, done, err, err_code, run_cycles};
    exp_v = {(m_st == 7) ? 4'd0 : 4'(m_st),
             (m_st >= 1 && m_st <= 5), (m_st == 6), (m_st == 7),
             m_code, m_cyc};
    chk("cycle", 64'(act_v), 64'(exp_v));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set(input logic s, input logic a, input logic [2:0] f);
    start = s; abort = a; fin_state = f;
  endtask

  task automatic step_fin(input logic [2:0] f);
    set(1'b0, 1'b0, f); tick(); set(1'b0, 1'b0, 3'd0);
  endtask

  int r;
  logic rs, ra;
  logic [2:0] rf;

  initial begin
    #1 rst = 1'b1;
    tick(); tick();
    chk("reset_en", 64'(en_state), 64'd0);
    chk("reset_cycles", 64'(run_cycles), 64'd0);
    rst = 1'b0;
    tick();

    // Nominal run: each completion code arrives 10 cycles after stage entry.
    set(1'b1, 1'b0, 3'd0); tick(); set(1'b0, 1'b0, 3'd0);
    chk("nom_en_hist", 64'(en_state), 64'd1);
    for (int k = 1; k <= 5; k++) begin
      repeat (10) tick();
      step_fin(3'(k + 1));
      chk("nom_en_step", 64'(en_state), 64'(k + 1));
    end
    chk("nom_done", 64'(done), 64'd1);
    chk("nom_cycles", 64'(run_cycles), 64'd55);
    tick();
    chk("nom_done_low", 64'(done), 64'd0);
    chk("nom_idle_hold", 64'({en_state, run_cycles}), 64'({4'd0, 32'd55}));

    // Illegal completion code in HTREE.
    set(1'b1, 1'b0, 3'd0); tick();
    step_fin(3'd2); step_fin(3'd3);
    chk("ill_in_htree", 64'(en_state), 64'd3);
    step_fin(3'd5);
    chk("ill_err", 64'({en_state, err, err_code}), 64'({4'd0, 1'b1, 3'd3}));
    repeat (3) tick();
    chk("ill_sticky", 64'({err, err_code}), 64'({1'b1, 3'd3}));
    set(1'b1, 1'b0, 3'd0); tick(); set(1'b0, 1'b0, 3'd0);
    chk("ill_restart", 64'({en_state, err, err_code}), 64'({4'd1, 1'b0, 3'd0}));
    set(1'b0, 1'b1, 3'd0); tick(); set(1'b0, 1'b0, 3'd0);

    // Abort and finish in the same TRANS cycle.
    set(1'b1, 1'b0, 3'd0); tick();
    step_fin(3'd2); step_fin(3'd3); step_fin(3'd4); step_fin(3'd5);
    chk("abt_in_trans", 64'(en_state), 64'd5);
    set(1'b0, 1'b1, 3'd6); tick(); set(1'b0, 1'b0, 3'd0);
    chk("abt_idle", 64'({en_state, done, err}), 64'({4'd0, 1'b0, 1'b0}));
    tick();
    chk("abt_no_done", 64'(done), 64'd0);

    // Watchdog in FLV (or indefinite hold without it).
    set(1'b1, 1'b0, 3'd0); tick();
    step_fin(3'd2);
    chk("wd_in_flv", 64'(en_state), 64'd2);
    if (WD) begin
      repeat (WDOG - 1) tick();
      chk("wd_before", 64'(en_state), 64'd2);
      tick();
      chk("wd_err", 64'({en_state, err, err_code}), 64'({4'd0, 1'b1, 3'd2}));
    end else begin
      repeat (1000) tick();
      chk("wd_hold", 64'({en_state, err}), 64'({4'd2, 1'b0}));
    end
    set(1'b0, 1'b1, 3'd0); tick(); set(1'b0, 1'b0, 3'd0);
    chk("wd_abort_clear", 64'({en_state, err, err_code}), 64'd0);

    // Asynchronous reset during CBS.
    set(1'b1, 1'b0, 3'd0); tick();
    step_fin(3'd2); step_fin(3'd3); step_fin(3'd4);
    chk("rst_in_cbs", 64'(en_state), 64'd4);
    #1 rst = 1'b1;
    #1 chk("rst_async", 64'({en_state, busy, run_cycles}), 64'd0);
    #2 rst = 1'b0;
    tick();
    chk("rst_after", 64'(en_state), 64'd0);

    // Start held during HIST does not restart the run.
    set(1'b1, 1'b0, 3'd0); tick();
    repeat (5) tick();
    chk("busy_start", 64'({en_state, run_cycles}), 64'({4'd1, 32'd5}));
    set(1'b0, 1'b1, 3'd0); tick(); set(1'b0, 1'b0, 3'd0);

    // Randomized traffic checked by the per-cycle comparison.
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(99));
      rs = ($urandom_range(3) == 0);
      ra = ($urandom_range(39) == 0);
      if (r < 70) rf = 3'd0;
      else if (r < 92 && m_st >= 1 && m_st <= 5) rf = 3'(m_st + 1);
      else rf = 3'($urandom_range(7));
      set(rs, ra, rf);
      tick();
    end
    set(1'b0, 1'b0, 3'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/t05_stage_sequencer.md
T05_STAGE_SEQUENCER -- requirements
Module: t05_stage_sequencer

Interface
REQ-001 SHALL have parameter WDOG_CYCLES, default 24'd1000000, the per-stage cycle limit before watchdog error.
REQ-002 SHALL have port clk  in  1  clock, rising-edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  in  1  request to begin one compression run.
REQ-005 SHALL have port abort  in  1  cancel the current run, return to idle.
REQ-006 SHALL have port fin_state  in  3  completion code from the active stage (0 = still working).
REQ-007 SHALL have port en_state  out  4  stage-enable code driven to all pipeline stages.
REQ-008 SHALL have port busy  out  1  high while a stage (en_state 1..5) is active.
REQ-009 SHALL have port done  out  1  one-cycle pulse on run completion.
REQ-010 SHALL have port err  out  1  sticky error flag.
REQ-011 SHALL have port err_code  out  3  stage number active when the error occurred.
REQ-012 SHALL have port run_cycles  out  32  cycle count of the current or last run.

Function
REQ-013 SHALL implement states IDLE, HIST, FLV, HTREE, CBS, TRANS, DONE, ERR with en_state 0, 1, 2, 3, 4, 5, 6, 0 respectively.
REQ-014 SHALL drive en_state, busy, done, err, err_code and run_cycles from registers, with no combinational path from inputs.
REQ-015 SHALL move IDLE -> HIST on the first clock edge with start=1.
REQ-016 SHALL, in stage k (1..5), advance to stage k+1 when fin_state == k+1; TRANS advances to DONE on fin_state == 6.
REQ-017 SHALL hold the current stage while fin_state == 0.
REQ-018 SHALL enter ERR with err_code = k when stage k sees a nonzero fin_state other than k+1.
REQ-019 SHALL stay in DONE exactly one cycle, with done=1 only in that cycle, then return to IDLE.
REQ-020 SHALL ignore start while busy or in DONE.
REQ-021 SHALL, on abort=1 in any state other than IDLE, go to IDLE on the next edge, with no done pulse and err/err_code cleared.
REQ-022 SHALL give abort priority over fin_state and the watchdog in the same cycle.
REQ-023 SHALL make ERR sticky: hold en_state=0, err=1, and err_code until start, abort or rst.
REQ-024 SHALL, on start in ERR, clear err and err_code and enter HIST.
REQ-025 SHALL clear run_cycles to 0 on the edge that accepts start.
REQ-026 SHALL increment run_cycles by 1 on every edge while busy, saturate at 32'hFFFFFFFF, and hold its value in DONE, IDLE and ERR.

Reset
REQ-027 SHALL, on rst, asynchronously force state IDLE, en_state 0, busy 0, done 0, err 0, err_code 0, run_cycles 0, and watchdog count 0.
REQ-028 SHALL, on rst during a stage, drop en_state to 0 immediately, without waiting for a clock edge.

Configuration
REQ-029 SHALL compile in the watchdog only when macro T05_STAGE_WDOG_EN is defined.
REQ-030 SHALL, with T05_STAGE_WDOG_EN defined, clear a 24-bit counter on every stage entry and increment it each cycle in a stage.
REQ-031 SHALL, with T05_STAGE_WDOG_EN defined, enter ERR with err_code = current stage once the counter reaches WDOG_CYCLES-1 without a valid fin_state.
REQ-032 SHALL give a valid fin_state priority over a watchdog expiry in the same cycle.
REQ-033 SHALL, without T05_STAGE_WDOG_EN, omit the counter entirely so a stage may stay active indefinitely.

Verification
REQ-034 SHALL cover a nominal run: start pulse, then fin_state 2,3,4,5,6 each asserted 10 cycles after stage entry -> en_state steps 1..5 then 6, done pulses once, and run_cycles = 55 (cycles in stages 1..5, each counted from entry through the fin_state cycle).
REQ-035 SHALL cover an illegal code: in HTREE (3), drive fin_state=5 -> en_state 0, err=1, err_code=3; a following start -> err=0, en_state=1.
REQ-036 SHALL cover abort vs finish: in TRANS, drive abort=1 and fin_state=6 in the same cycle -> IDLE, no done pulse, err=0.
REQ-037 SHALL cover the watchdog: with T05_STAGE_WDOG_EN and WDOG_CYCLES=16, hold fin_state=0 in FLV -> ERR with err_code=2 on the 16th cycle; without the macro, still in FLV after 1000 cycles.
REQ-038 SHALL cover mid-run reset and busy start: assert rst asynchronously in CBS -> en_state=0 before the next edge; start during HIST -> no restart, run_cycles keeps counting.
